ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter: HILO_RESET, default 32'h0, value loaded into HI and LO on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ex_mult  input  1  EX-stage instruction is MULT/MULTU.
REQ-005 ex_div  input  1  EX-stage instruction is DIV/DIVU.
REQ-006 ex_mdsign  input  1  1 = signed op (MULT/DIV), 0 = unsigned.
REQ-007 ex_A  input  32  GPR[rs]: multiplicand/dividend, MTHI/MTLO source.
REQ-008 ex_B  input  32  GPR[rt]: multiplier/divisor.
REQ-009 ex_hilowen  input  2  bit1 = write HI, bit0 = write LO (MTHI/MTLO).
REQ-010 ex_hiloren  input  2  bit1 = read HI, bit0 = read LO (MFHI/MFLO).
REQ-011 ex_stall  input  1  downstream hold of the EX stage.
REQ-012 flush  input  1  kill the EX-stage instruction (exception/ERET refresh).
REQ-013 md_busy  output  1  EX must stall; unit still computing.
REQ-014 hilo_rdata  output  32  MFHI/MFLO read data.
REQ-015 hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-016 FSM states SHALL be IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-017 Start: in IDLE with (ex_mult|ex_div) and !flush, SHALL capture operand magnitudes (abs value when ex_mdsign, raw otherwise) and result-sign flags, then go to MUL or DIV.
REQ-018 ex_mult and ex_div both high SHALL be treated as ex_mult.
REQ-019 md_busy SHALL be asserted combinationally in the start cycle and throughout MUL/DIV, deasserted in IDLE (no start) and DONE, and forced 0 whenever flush=1.
REQ-020 MUL SHALL last 1 cycle: 32x32 unsigned product of magnitudes into a 64-bit result register, negated (two's complement, 64-bit) if signed and operand signs differ; then DONE.
REQ-021 MULT total busy = 2 cycles (start + MUL).
REQ-022 DIV SHALL run a radix-2 restoring divide, one quotient bit per cycle, 32 cycles, 6-bit counter 0..31; DIV->DONE when counter = 31.
REQ-023 DIV total busy = 33 cycles (start + 32).
REQ-024 Signed DIV: quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-025 Divide by zero (magnitudes): quotient magnitude 32'hFFFFFFFF, remainder magnitude = dividend magnitude, then REQ-024 sign fixups; no exception.
REQ-026 Result mapping: MULT HI = product[63:32], LO = product[31:0]; DIV LO = quotient, HI = remainder.
REQ-027 DONE SHALL hold while ex_stall=1; on the DONE-exit edge go to IDLE and commit the result into HI/LO if flush=0, discard if flush=1.
REQ-028 No restart from DONE; the finished instruction still presented in DONE SHALL NOT retrigger.
REQ-029 flush in MUL or DIV SHALL return FSM to IDLE on the next edge, HI/LO unchanged.
REQ-030 MTHI/MTLO: in IDLE with !ex_mult, !ex_div, !flush, !ex_stall, each set bit of ex_hilowen SHALL write ex_A into HI/LO on that edge.
REQ-031 ex_hilowen SHALL be ignored whenever ex_mult or ex_div is high.
REQ-032 hilo_rdata SHALL be HI if ex_hiloren[1], else LO if ex_hiloren[0], else 0; combinational from the HI/LO registers (no bypass of uncommitted result).
REQ-033 All arithmetic SHALL be modulo 2^32 / 2^64; magnitude of 32'h80000000 is 2^31 (33-bit internal magnitude path not required; unsigned 32-bit holds it).

Reset
REQ-034 On reset (including mid-MUL/DIV): state IDLE, HI = LO = HILO_RESET, counter 0, result regs 0, md_busy 0, hilo_rdata 0 when ex_hiloren=0.
REQ-035 Reset SHALL take priority over flush, start, and MTHI/MTLO writes.

Verification
REQ-036 Signed MULT A=32'hFFFFFFFE, B=3 -> md_busy 2 cycles, after DONE exit HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-037 MULTU A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
REQ-038 Signed DIV A=32'hFFFFFFF9 (-7), B=2 -> md_busy 33 cycles, LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; with ex_stall high 3 cycles in DONE, commit delayed 3 cycles, no restart.
REQ-039 DIVU A=100, B=0 -> LO=32'hFFFFFFFF, HI=32'd100.
REQ-040 flush asserted in DIV cycle 10 -> md_busy 0 that cycle, IDLE next, HI/LO unchanged; flush in DONE -> HI/LO unchanged.
REQ-041 MTLO 32'h1234 then MFLO next cycle -> hilo_rdata=32'h1234; reset pulse mid-DIV -> HI=LO=0, md_busy=0 next cycle.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/DIV unit with architectural HI/LO registers.
// Single-cycle multiply and 32-step restoring divide; results commit to HI/LO on DONE exit.
module ex_muldiv #(
  parameter logic [31:0] HILO_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mult,
  input  logic        ex_div,
  input  logic        ex_mdsign,
  input  logic [31:0] ex_A,
  input  logic [31:0] ex_B,
  input  logic [1:0]  ex_hilowen,
  input  logic [1:0]  ex_hiloren,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        md_busy,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t      state_q;
  logic [31:0] hi_q, lo_q, b_q, ma, mb, qn, rn;
  logic [63:0] res_q, prod;
  logic [5:0]  cnt_q;
  logic        neg_q, rneg_q, sa, sb, start;
  logic [32:0] sh, diff;
  assign start = state_q == IDLE && (ex_mult || ex_div) && !flush;
  assign sa = ex_mdsign & ex_A[31];
  assign sb = ex_mdsign & ex_B[31];
  assign ma = sa ? -ex_A : ex_A;
  assign mb = sb ? -ex_B : ex_B;
  // res_q doubles as {partial remainder, dividend/quotient} shift pair during DIV
  assign sh = {res_q[63:32], res_q[31]};
  assign diff = sh - {1'b0, b_q};
  assign qn = {res_q[30:0], ~diff[32]};
  assign rn = diff[32] ? sh[31:0] : diff[31:0];
  assign prod = {32'b0, res_q[31:0]} * {32'b0, b_q};
  assign md_busy = !flush && (start || state_q == MUL || state_q == DIV);
  assign hilo_rdata = ex_hiloren[1] ? hi_q : ex_hiloren[0] ? lo_q : 32'b0;
  assign hi = hi_q;
  assign lo = lo_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hi_q    <= HILO_RESET;
      lo_q    <= HILO_RESET;
      cnt_q   <= '0;
      res_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            res_q   <= {32'b0, ma};
            b_q     <= mb;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            cnt_q   <= '0;
            state_q <= ex_mult ? MUL : DIV;
          end else if (!ex_mult && !ex_div && !flush && !ex_stall) begin
            if (ex_hilowen[1]) hi_q <= ex_A;
            if (ex_hilowen[0]) lo_q <= ex_A;
          end
        end
        MUL: begin
          if (!flush) res_q <= neg_q ? -prod : prod;
          state_q <= flush ? IDLE : DONE;
        end
        DIV: begin
          if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 6'd31) begin
            res_q   <= {rneg_q ? -rn : rn, neg_q ? -qn : qn};
            state_q <= DONE;
          end else begin
            res_q <= {rn, qn};
            cnt_q <= cnt_q + 6'd1;
          end
        end
        default: begin
          if (!ex_stall) begin
            state_q <= IDLE;
            if (!flush) {hi_q, lo_q} <= res_q;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized self-checking bench for ex_muldiv against an arithmetic HI/LO model.
module tb_ex_muldiv;
  logic        clk = 1'b0, reset, ex_mult, ex_div, ex_mdsign, ex_stall, flush;
  logic [31:0] ex_A, ex_B;
  logic [1:0]  ex_hilowen, ex_hiloren;
  logic        md_busy;
  logic [31:0] hilo_rdata, hi, lo;
  int          nvec = 0, nerr = 0;
  logic [31:0] exp_hi = 32'h0, exp_lo = 32'h0;

  ex_muldiv dut (
    .clk(clk), .reset(reset), .ex_mult(ex_mult), .ex_div(ex_div), .ex_mdsign(ex_mdsign),
    .ex_A(ex_A), .ex_B(ex_B), .ex_hilowen(ex_hilowen), .ex_hiloren(ex_hiloren),
    .ex_stall(ex_stall), .flush(flush), .md_busy(md_busy), .hilo_rdata(hilo_rdata),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Returns {HI, LO} as the architecture defines them for one MULT(U)/DIV(U).
  function automatic logic [63:0] model(input logic m, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb;
    logic [31:0] ma, mb, q, r;
    logic sa, sb;
    if (m) begin
      pa = s ? {{32{a[31]}}, a} : {32'b0, a};
      pb = s ? {{32{b[31]}}, b} : {32'b0, b};
      return pa * pb;
    end
    sa = s && a[31];
    sb = s && b[31];
    ma = sa ? 32'd0 - a : a;
    mb = sb ? 32'd0 - b : b;
    q = (mb == 0) ? 32'hFFFFFFFF : ma / mb;
    r = (mb == 0) ? ma : ma % mb;
    if (sa != sb) q = 32'd0 - q;
    if (sa) r = 32'd0 - r;
    return {r, q};
  endfunction

  task automatic do_op(input logic m, input logic d, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    logic [63:0] e;
    int n;
    e = model(m, s, a, b);
    @(negedge clk);
    ex_mult = m; ex_div = d; ex_mdsign = s; ex_A = a; ex_B = b; ex_hilowen = 2'b11; ex_stall = 1'b0;
    #1;
    n = 0;
    while (md_busy && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    nvec++;
    if (n !== (m ? 2 : 33)) begin
      nerr++;
      $display("FAIL busy_cycles m=%0b s=%0b a=%h b=%h got %0d exp %0d", m, s, a, b, n, m ? 2 : 33);
    end
    for (int i = 0; i < stall; i++) begin
      ex_stall = 1'b1;
      @(negedge clk);
      #1;
      nvec++;
      if (md_busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
        nerr++;
        $display("FAIL done_hold busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", md_busy, hi, lo, exp_hi, exp_lo);
      end
    end
    ex_stall = 1'b0;
    @(negedge clk);
    ex_mult = 1'b0; ex_div = 1'b0; ex_hilowen = 2'b00;
    #1;
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    nvec++;
    if (hi !== exp_hi || lo !== exp_lo || md_busy !== 1'b0) begin
      nerr++;
      $display("FAIL commit m=%0b s=%0b a=%h b=%h got hi=%h lo=%h busy=%b exp hi=%h lo=%h busy=0",
               m, s, a, b, hi, lo, md_busy, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ex_mult = 0; ex_div = 0; ex_mdsign = 0; ex_A = 0; ex_B = 0;
    ex_hilowen = 0; ex_hiloren = 0; ex_stall = 0; flush = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    nvec++;
    if (hi !== 32'h0 || lo !== 32'h0 || md_busy !== 1'b0 || hilo_rdata !== 32'h0) begin
      nerr++;
      $display("FAIL reset_state hi=%h lo=%h busy=%b rdata=%h exp all 0", hi, lo, md_busy, hilo_rdata);
    end
  endtask

  task automatic test_mthilo();
    logic [31:0] v;
    v = $urandom;
    @(negedge clk); ex_hilowen = 2'b01; ex_A = 32'h1234;
    @(negedge clk); ex_hilowen = 2'b00; ex_hiloren = 2'b01; exp_lo = 32'h1234;
    #1; nvec++;
    if (hilo_rdata !== 32'h1234) begin nerr++; $display("FAIL mflo got %h exp %h", hilo_rdata, 32'h1234); end
    @(negedge clk); ex_hilowen = 2'b10; ex_A = v; ex_hiloren = 2'b00;
    #1; nvec++;
    if (hilo_rdata !== 32'h0) begin nerr++; $display("FAIL rdata_none got %h exp 0", hilo_rdata); end
    @(negedge clk); ex_hilowen = 2'b00; ex_hiloren = 2'b11; exp_hi = v;
    #1; nvec++;
    if (hilo_rdata !== v) begin nerr++; $display("FAIL mfhi_prio got %h exp %h", hilo_rdata, v); end
    @(negedge clk); ex_hilowen = 2'b01; ex_A = ~v; ex_stall = 1'b1; ex_hiloren = 2'b01;
    @(negedge clk); ex_hilowen = 2'b00; ex_stall = 1'b0;
    #1; nvec++;
    if (hilo_rdata !== 32'h1234) begin nerr++; $display("FAIL mtlo_stalled got %h exp %h", hilo_rdata, 32'h1234); end
    ex_hiloren = 2'b00;
  endtask

  task automatic test_directed();
    do_op(1, 0, 1, 32'hFFFFFFFE, 32'd3, 0);
    nvec++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      nerr++; $display("FAIL mult_neg got hi=%h lo=%h exp hi=ffffffff lo=fffffffa", hi, lo);
    end
    do_op(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    nvec++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      nerr++; $display("FAIL multu_max got hi=%h lo=%h exp hi=fffffffe lo=00000001", hi, lo);
    end
    do_op(0, 1, 1, 32'hFFFFFFF9, 32'd2, 3);
    nvec++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      nerr++; $display("FAIL div_neg got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo);
    end
    do_op(0, 1, 0, 32'd100, 32'd0, 1);
    nvec++;
    if (hi !== 32'd100 || lo !== 32'hFFFFFFFF) begin
      nerr++; $display("FAIL divu_zero got hi=%h lo=%h exp hi=00000064 lo=ffffffff", hi, lo);
    end
    do_op(1, 1, 1, 32'h80000000, 32'h80000000, 0);
    do_op(0, 1, 1, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(0, 1, 1, 32'd7, 32'hFFFFFFFE, 2);
  endtask

  task automatic test_flush();
    int n;
    @(negedge clk); ex_div = 1'b1; ex_mdsign = 1'b0; ex_A = $urandom; ex_B = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1; nvec++;
    if (md_busy !== 1'b0) begin nerr++; $display("FAIL flush_div_busy got %b exp 0", md_busy); end
    @(negedge clk); flush = 1'b0; ex_div = 1'b0;
    #1; nvec++;
    if (md_busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      nerr++; $display("FAIL flush_div_idle busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", md_busy, hi, lo, exp_hi, exp_lo);
    end
    @(negedge clk); ex_mult = 1'b1; ex_A = $urandom; ex_B = $urandom;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; ex_mult = 1'b0;
    repeat (2) @(negedge clk);
    #1; nvec++;
    if (md_busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
      nerr++; $display("FAIL flush_mul busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h", md_busy, hi, lo, exp_hi, exp_lo);
    end
    @(negedge clk); ex_div = 1'b1; ex_A = $urandom; ex_B = 32'd5;
    #1; n = 0;
    while (md_busy && n < 40) begin n++; @(negedge clk); #1; end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; ex_div = 1'b0;
    #1; nvec++;
    if (n !== 33 || hi !== exp_hi || lo !== exp_lo) begin
      nerr++; $display("FAIL flush_done cycles=%0d hi=%h lo=%h exp cycles=33 hi=%h lo=%h", n, hi, lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_random();
    logic m, s;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      m = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      do_op(m, !m, s, a, b, $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); ex_div = 1'b1; ex_mdsign = 1'b1; ex_A = $urandom; ex_B = $urandom;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; ex_div = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    #1; nvec++;
    if (md_busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      nerr++; $display("FAIL reset_mid busy=%b hi=%h lo=%h exp all 0", md_busy, hi, lo);
    end
    do_op(1, 0, 0, 32'd6, 32'd7, 0);
  endtask

  initial begin
    test_reset();
    test_mthilo();
    test_directed();
    test_flush();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
